// File: rtl/if_fetch_pkg.sv
// Purpose: shared constants and FSM state encoding for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_pkg;

  localparam logic [31:0] NOP_INS = 32'hdc00_0000;  // bubble instruction
  localparam logic [31:0] PC_STEP = 32'd4;          // sequential PC increment (bytes)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Purpose: instruction-fetch stage; owns the PC, issues one outstanding imem request at a
//          time and presents {pc_out, ins_out, valid_out} to the F/D register.
// Latency: response sampled at edge t+k appears on the outputs right after that edge.
// Backpressure: stall freezes outputs; a response arriving under stall parks in a hold
//          buffer and no new request is issued until stall drops.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   jump_valid, jump_target  decode redirect (highest priority, ignores stall)
//   stall                    downstream cannot accept
//   imem_req/addr/ready      request handshake (accept = req & ready)
//   imem_rvalid/rdata        in-order response
//   pc_out, ins_out, valid_out  registered fetch result (ins_out = NOP_INS when invalid)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = if_fetch_pkg::NOP_INS,
  parameter logic [31:0] PC_STEP  = if_fetch_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ins_out,
  output logic        valid_out
);

  import if_fetch_pkg::*;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;   // address of the request currently outstanding
  logic         req_q;
  logic [31:0]  pc_out_q;
  logic [31:0]  ins_q;
  logic         valid_q;
  logic [63:0]  hold_q;       // {pc, instruction} parked while stalled
  logic         hold_vld_q;

  logic [31:0]  pc_inc_d;
  logic         accept_d;
  logic         outstanding_d;

  assign pc_inc_d = pc_q + PC_STEP;  // 32-bit modulo wrap is intended
  assign accept_d = req_q & imem_ready;

  // On a redirect, a response is still owed to us if a request is accepted right now,
  // or one is in flight and its data is not arriving on this very edge.
  assign outstanding_d = (state_q == ST_REQ   && accept_d) ||
                         (state_q == ST_WAIT  && !imem_rvalid) ||
                         (state_q == ST_DRAIN && !imem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= 32'h0;
      req_q      <= 1'b0;
      pc_out_q   <= 32'h0;
      ins_q      <= NOP_INS;
      valid_q    <= 1'b0;
      hold_q     <= 64'h0;
      hold_vld_q <= 1'b0;
    end else begin
      // Without stall every edge that does not deliver a word shows a bubble.
      if (!stall) begin
        valid_q <= 1'b0;
        ins_q   <= NOP_INS;
      end

      if (jump_valid) begin
        pc_q       <= jump_target;
        valid_q    <= 1'b0;
        ins_q      <= NOP_INS;
        hold_vld_q <= 1'b0;
        if (outstanding_d) begin
          state_q <= ST_DRAIN;
          req_q   <= 1'b0;
        end else begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
          ST_REQ: begin
            if (accept_d) begin
              fetch_pc_q <= pc_q;
              state_q    <= ST_WAIT;
              req_q      <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid) begin
              if (!stall) begin
                pc_out_q <= fetch_pc_q;
                ins_q    <= imem_rdata;
                valid_q  <= 1'b1;
                pc_q     <= pc_inc_d;
                state_q  <= ST_REQ;
                req_q    <= 1'b1;
              end else begin
                hold_q     <= {fetch_pc_q, imem_rdata};
                hold_vld_q <= 1'b1;
                state_q    <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (!stall && hold_vld_q) begin
              pc_out_q   <= hold_q[63:32];
              ins_q      <= hold_q[31:0];
              valid_q    <= 1'b1;
              hold_vld_q <= 1'b0;
              pc_q       <= pc_inc_d;
              state_q    <= ST_REQ;
              req_q      <= 1'b1;
            end
          end
          ST_DRAIN: begin
            // The stale word is simply dropped.
            if (imem_rvalid) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign ins_out   = ins_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Purpose: self-checking bench for if_fetch: directed scenarios, then a randomized run
//          checked against a program-order stream model of the fetch stage.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: stall/ready/latency randomized in the second phase.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'hdc00_0000;

  logic        clk;
  logic        rst;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req,  imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] pc_out,    pc_out2;
  logic [31:0] ins_out,   ins_out2;
  logic        valid_out, valid_out2;

  int checks = 0;
  int errors = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .jump_valid(jump_valid), .jump_target(jump_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .ins_out(ins_out), .valid_out(valid_out)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .jump_valid(jump_valid), .jump_target(jump_target),
    .stall(stall), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_out(pc_out2),
    .ins_out(ins_out2), .valid_out(valid_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From REQ with ready=1: accept at addr, respond one cycle later, check delivery.
  task automatic fetch_one(input logic [31:0] addr);
    chk("req_on", 32'(imem_req), 32'd1);
    chk("req_addr", imem_addr, addr);
    tick();
    chk("bubble_valid", 32'(valid_out), 32'd0);
    chk("bubble_ins", ins_out, NOP);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(addr);
    tick();
    imem_rvalid = 1'b0;
    chk("dlv_valid", 32'(valid_out), 32'd1);
    chk("dlv_pc", pc_out, addr);
    chk("dlv_ins", ins_out, mem_word(addr));
  endtask

  logic [31:0] pend_a[$];
  int          pend_due[$];
  logic [31:0] exp_pc, a, pp, pi;
  logic        acc, rv, pv;
  int          deliveries;

  initial begin
    rst = 1'b1; jump_valid = 1'b0; jump_target = 32'h0; stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    deliveries = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_ins", ins_out, NOP);
    chk("rst_pc_out", pc_out, 32'h0);

    // 1: sequential fetch, one bubble between responses
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) fetch_one(32'(i * 4));

    // 2: response under stall parks, released when stall drops
    chk("t2_addr", imem_addr, 32'd12);
    tick();
    stall = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("t2_frz_valid", 32'(valid_out), 32'd0);
    chk("t2_frz_ins", ins_out, NOP);
    chk("t2_hold_noreq", 32'(imem_req), 32'd0);
    tick();
    chk("t2_frz_ins2", ins_out, NOP);
    chk("t2_hold_noreq2", 32'(imem_req), 32'd0);
    stall = 1'b0;
    tick();
    chk("t2_rel_ins", ins_out, 32'h1234_5678);
    chk("t2_rel_valid", 32'(valid_out), 32'd1);
    chk("t2_rel_pc", pc_out, 32'd12);

    // 3: jump while waiting; stale word arrives 2 cycles later and is dropped
    chk("t3_addr", imem_addr, 32'd16);
    tick();
    jump_valid = 1'b1;
    jump_target = 32'h100;
    tick();
    jump_valid = 1'b0;
    chk("t3_j_valid", 32'(valid_out), 32'd0);
    chk("t3_j_ins", ins_out, NOP);
    chk("t3_drain_noreq", 32'(imem_req), 32'd0);
    tick();
    chk("t3_drain_noreq2", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("t3_stale_ins", ins_out, NOP);
    chk("t3_stale_valid", 32'(valid_out), 32'd0);
    fetch_one(32'h100);

    // 4: jump coincident with response: no drain
    tick();
    jump_valid = 1'b1;
    jump_target = 32'h200;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    tick();
    jump_valid = 1'b0;
    imem_rvalid = 1'b0;
    chk("t4_ins", ins_out, NOP);
    chk("t4_valid", 32'(valid_out), 32'd0);
    fetch_one(32'h200);

    // 5: memory not ready for 5 cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_req", 32'(imem_req), 32'd1);
      chk("t5_addr", imem_addr, 32'h204);
      chk("t5_valid", 32'(valid_out), 32'd0);
      chk("t5_ins", ins_out, NOP);
      chk("t5_pc_out", pc_out, 32'h200);
    end
    imem_ready = 1'b1;
    fetch_one(32'h204);
    exp_pc = 32'h208;

    // Randomized run against the stream model
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      jump_valid  = ($urandom_range(0, 24) == 0);
      jump_target = $urandom & 32'hFFFF_FFFC;
      imem_ready  = ($urandom_range(0, 2) != 0);
      rv          = (pend_a.size() > 0) && (c >= pend_due[0]);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(pend_a[0]) : $urandom;
      acc = imem_req && imem_ready;
      a   = imem_addr;
      pv  = valid_out;
      pp  = pc_out;
      pi  = ins_out;
      tick();
      if (acc && !jump_valid) chk("r_acc_addr", a, exp_pc);
      if (rv) begin
        void'(pend_a.pop_front());
        void'(pend_due.pop_front());
      end
      if (acc) begin
        pend_a.push_back(a);
        pend_due.push_back(c + 1 + $urandom_range(0, 2));
      end
      if (jump_valid) begin
        chk("r_jmp_valid", 32'(valid_out), 32'd0);
        chk("r_jmp_ins", ins_out, NOP);
        exp_pc = jump_target;
      end else if (stall) begin
        chk("r_stall_valid", 32'(valid_out), 32'(pv));
        chk("r_stall_pc", pc_out, pp);
        chk("r_stall_ins", ins_out, pi);
      end else if (valid_out) begin
        chk("r_dlv_pc", pc_out, exp_pc);
        chk("r_dlv_ins", ins_out, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        chk("r_bubble_ins", ins_out, NOP);
      end
    end
    chk("r_progress", 32'(deliveries > 100), 32'd1);

    // 6: wrap-around PC and reset in WAIT (second instance)
    jump_valid = 1'b0; stall = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t6_req", 32'(imem_req2), 32'd1);
    chk("t6_addr0", imem_addr2, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = mem_word(32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b0;
    chk("t6_dlv_pc", pc_out2, 32'hFFFF_FFFC);
    chk("t6_dlv_valid", 32'(valid_out2), 32'd1);
    chk("t6_wrap_addr", imem_addr2, 32'h0);
    tick();
    chk("t6_wait_noreq", 32'(imem_req2), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 32'(valid_out2), 32'd0);
    chk("t6_rst_ins", ins_out2, NOP);
    chk("t6_rst_pc_out", pc_out2, 32'h0);
    chk("t6_rst_req", 32'(imem_req2), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD1_BAD1;
    tick();
    imem_rvalid = 1'b0;
    chk("t6_late_ins", ins_out2, NOP);
    chk("t6_late_valid", 32'(valid_out2), 32'd0);
    chk("t6_late_req", 32'(imem_req2), 32'd1);
    chk("t6_late_addr", imem_addr2, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
